kernel_window_reader: RTL and testbench

- Read-side companion to the line-interleaved 1-bit frame store: three BRAM banks, where row r lives in bank r%3 at line r/3.
- Owns the B (read) ports of all three banks and walks one stored frame in raster order.
- Emits one 3x3 binary kernel per pixel, replicating edge pixels, over a valid/ready handshake.
- Feeds the downstream erosion/dilation/pose-feature stages.

---
 rtl/kernel_window_reader_pkg.sv | 59 +++++
 rtl/kernel_window_reader_bank_row_addr.sv | 59 +++++
 rtl/kernel_window_reader.sv | 210 +++++++++++++++++++++
 tb/tb_kernel_window_reader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_window_reader_pkg.sv
// Shared geometry, FSM encoding and kernel bit layout for the 3x3 window reader.
// Kernel bit index is 3*row+col (row 0 = top, col 0 = left).
package kernel_pkg;

   localparam int X           = 320;
   localparam int THIRD_OF_Y  = 80;
   localparam int Y           = 3 * THIRD_OF_Y;
   localparam int FRAME_WORDS = X * THIRD_OF_Y;
   localparam int ADDR_W      = 17;

   typedef enum logic [2:0] {
      IDLE,
      P_RD,
      P_WT,
      RD,
      WT,
      EMIT,
      DONE
   } kstate_e;

   localparam int KTL     = 0;
   localparam int KTC     = 1;
   localparam int KTR     = 2;
   localparam int KML     = 3;
   localparam int KCENTRE = 4;
   localparam int KMR     = 5;
   localparam int KBL     = 6;
   localparam int KBC     = 7;
   localparam int KBR     = 8;

   // Column registers hold {bottom, mid, top} in bits [2:0].
   function automatic logic [8:0] pack_kernel(input logic [2:0] l, input logic [2:0] c,
                                               input logic [2:0] r);
      logic [8:0] k;
      k          = '0;
      k[KTL]     = l[0];
      k[KTC]     = c[0];
      k[KTR]     = r[0];
      k[KML]     = l[1];
      k[KCENTRE] = c[1];
      k[KMR]     = r[1];
      k[KBL]     = l[2];
      k[KBC]     = c[2];
      k[KBR]     = r[2];
      return k;
   endfunction

   function automatic logic pick_bank(input logic [1:0] sel, input logic a, input logic b,
                                      input logic c);
      logic v;
      case (sel)
         2'd0:    v = a;
         2'd1:    v = b;
         default: v = c;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/kernel_window_reader_bank_row_addr.sv
// Maps the clamped top/mid/bottom rows onto bank addresses for one column.
// A bank that serves no row this column gets address 0.
module bank_row_addr
   import kernel_pkg::*;
#(
   parameter int X  = kernel_pkg::X,
   parameter int AW = ADDR_W
) (
   input  logic [1:0]    i_top_bank,
   input  logic [7:0]    i_top_line,
   input  logic [1:0]    i_mid_bank,
   input  logic [7:0]    i_mid_line,
   input  logic [1:0]    i_bot_bank,
   input  logic [7:0]    i_bot_line,
   input  logic [8:0]    i_col,
   input  logic [AW-1:0] i_base,
   output logic [AW-1:0] o_addr_a,
   output logic [AW-1:0] o_addr_b,
   output logic [AW-1:0] o_addr_c,
   output logic [1:0]    o_sel_top,
   output logic [1:0]    o_sel_mid,
   output logic [1:0]    o_sel_bot
);

   logic [AW-1:0] w_top_addr;
   logic [AW-1:0] w_mid_addr;
   logic [AW-1:0] w_bot_addr;

   assign w_top_addr = i_base + (AW'(i_top_line) * AW'(X)) + AW'(i_col);
   assign w_mid_addr = i_base + (AW'(i_mid_line) * AW'(X)) + AW'(i_col);
   assign w_bot_addr = i_base + (AW'(i_bot_line) * AW'(X)) + AW'(i_col);

   assign o_sel_top = i_top_bank;
   assign o_sel_mid = i_mid_bank;
   assign o_sel_bot = i_bot_bank;

   // At frame edges two rows share a bank; they are the same row, so the writes agree.
   always_comb begin
      o_addr_a = '0;
      o_addr_b = '0;
      o_addr_c = '0;
      case (i_top_bank)
         2'd0:    o_addr_a = w_top_addr;
         2'd1:    o_addr_b = w_top_addr;
         default: o_addr_c = w_top_addr;
      endcase
      case (i_mid_bank)
         2'd0:    o_addr_a = w_mid_addr;
         2'd1:    o_addr_b = w_mid_addr;
         default: o_addr_c = w_mid_addr;
      endcase
      case (i_bot_bank)
         2'd0:    o_addr_a = w_bot_addr;
         2'd1:    o_addr_b = w_bot_addr;
         default: o_addr_c = w_bot_addr;
      endcase
   end

endmodule

// File: rtl/kernel_window_reader.sv
// Walks one stored 1-bit frame in raster order and emits an edge-replicated 3x3
// kernel per pixel from the three line-interleaved BRAM banks.
module kernel_window_reader #(
   parameter int X          = kernel_pkg::X,
   parameter int THIRD_OF_Y = kernel_pkg::THIRD_OF_Y,
   parameter int RD_LAT     = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  frame_sel,
   output logic        busy,
   output logic        done,
   output logic        rd_en,
   output logic [16:0] rd_addr_a,
   output logic [16:0] rd_addr_b,
   output logic [16:0] rd_addr_c,
   input  logic        rd_data_a,
   input  logic        rd_data_b,
   input  logic        rd_data_c,
   output logic [8:0]  kernel_out,
   output logic        kernel_valid,
   input  logic        kernel_ready,
   output logic [8:0]  kernel_x,
   output logic [7:0]  kernel_y,
   output logic        kernel_last,
   output logic [2:0]  dbg_state
);
   import kernel_pkg::*;

   localparam int         NY     = 3 * THIRD_OF_Y;
   localparam int         FW     = X * THIRD_OF_Y;
   localparam logic [8:0] X_LAST = 9'(X - 1);
   localparam logic [7:0] Y_LAST = 8'(NY - 1);

   if (RD_LAT != 1) begin : g_rd_lat_unsupported
      $error("kernel_window_reader: only RD_LAT = 1 is supported");
   end

   kstate_e     r_state;
   kstate_e     w_nxt_state;
   logic [8:0]  r_x;
   logic [7:0]  r_y;
   logic [1:0]  r_mb;
   logic [7:0]  r_ml;
   logic [16:0] r_base;
   logic [2:0]  r_l;
   logic [2:0]  r_c;
   logic [2:0]  r_r;

   logic [1:0]  w_top_bank;
   logic [7:0]  w_top_line;
   logic [1:0]  w_bot_bank;
   logic [7:0]  w_bot_line;
   logic [8:0]  w_col;
   logic [16:0] w_sel_base;
   logic [1:0]  w_sel_top;
   logic [1:0]  w_sel_mid;
   logic [1:0]  w_sel_bot;
   logic [2:0]  w_cap;

   // Neighbour rows derived from the mid-row bank/line counters; clamped at the edges.
   always_comb begin
      w_top_bank = r_mb;
      w_top_line = r_ml;
      w_bot_bank = r_mb;
      w_bot_line = r_ml;
      if (r_y != 8'd0) begin
         if (r_mb == 2'd0) begin
            w_top_bank = 2'd2;
            w_top_line = r_ml - 8'd1;
         end else begin
            w_top_bank = r_mb - 2'd1;
         end
      end
      if (r_y != Y_LAST) begin
         if (r_mb == 2'd2) begin
            w_bot_bank = 2'd0;
            w_bot_line = r_ml + 8'd1;
         end else begin
            w_bot_bank = r_mb + 2'd1;
         end
      end
   end

   assign w_col = (r_state != RD) ? 9'd0 : ((r_x == X_LAST) ? r_x : r_x + 9'd1);

   always_comb begin
      case (frame_sel)
         2'd1:    w_sel_base = 17'(FW);
         2'd2:    w_sel_base = 17'(2 * FW);
         default: w_sel_base = 17'd0;
      endcase
   end

   bank_row_addr #(
      .X  (X),
      .AW (17)
   ) u_bank_row_addr (
      .i_top_bank (w_top_bank),
      .i_top_line (w_top_line),
      .i_mid_bank (r_mb),
      .i_mid_line (r_ml),
      .i_bot_bank (w_bot_bank),
      .i_bot_line (w_bot_line),
      .i_col      (w_col),
      .i_base     (r_base),
      .o_addr_a   (rd_addr_a),
      .o_addr_b   (rd_addr_b),
      .o_addr_c   (rd_addr_c),
      .o_sel_top  (w_sel_top),
      .o_sel_mid  (w_sel_mid),
      .o_sel_bot  (w_sel_bot)
   );

   assign w_cap = {pick_bank(w_sel_bot, rd_data_a, rd_data_b, rd_data_c),
                   pick_bank(w_sel_mid, rd_data_a, rd_data_b, rd_data_c),
                   pick_bank(w_sel_top, rd_data_a, rd_data_b, rd_data_c)};

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_nxt_state;
   end

   // Handshake: kernel_valid rises in EMIT and, with kernel_out and tags frozen,
   // holds until kernel_ready is high at a clk edge; that edge is the transfer.
   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         IDLE: if (start) w_nxt_state = P_RD;
         P_RD: w_nxt_state = P_WT;
         P_WT: w_nxt_state = RD;
         RD:   w_nxt_state = WT;
         WT:   w_nxt_state = EMIT;
         EMIT: begin
            if (kernel_ready) begin
               if (r_x != X_LAST)      w_nxt_state = RD;
               else if (r_y != Y_LAST) w_nxt_state = P_RD;
               else                    w_nxt_state = DONE;
            end
         end
         DONE:    w_nxt_state = IDLE;
         default: w_nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_mb   <= '0;
         r_ml   <= '0;
         r_base <= '0;
         r_l    <= '0;
         r_c    <= '0;
         r_r    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_base <= w_sel_base;
                  r_x    <= '0;
                  r_y    <= '0;
                  r_mb   <= '0;
                  r_ml   <= '0;
               end
            end
            P_WT: begin
               // Column 0 fills L as well, replicating the left edge.
               r_l <= w_cap;
               r_c <= w_cap;
               r_r <= w_cap;
            end
            WT: begin
               r_l <= r_c;
               r_c <= r_r;
               r_r <= w_cap;
            end
            EMIT: begin
               if (kernel_ready) begin
                  if (r_x != X_LAST) begin
                     r_x <= r_x + 9'd1;
                  end else if (r_y != Y_LAST) begin
                     r_x <= '0;
                     r_y <= r_y + 8'd1;
                     if (r_mb == 2'd2) begin
                        r_mb <= 2'd0;
                        r_ml <= r_ml + 8'd1;
                     end else begin
                        r_mb <= r_mb + 2'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = (r_state != IDLE) && (r_state != DONE);
   assign done         = (r_state == DONE);
   assign rd_en        = (r_state == P_RD) || (r_state == RD);
   assign kernel_valid = (r_state == EMIT);
   assign kernel_out   = pack_kernel(r_l, r_c, r_r);
   assign kernel_x     = r_x;
   assign kernel_y     = r_y;
   assign kernel_last  = (r_state == EMIT) && (r_x == X_LAST) && (r_y == Y_LAST);
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_kernel_window_reader.sv
// Scoreboard bench for kernel_window_reader on a 4x3 frame with three frame slots.
module tb_kernel_window_reader;

  localparam int NX = 4;
  localparam int NT = 1;
  localparam int NY = 3 * NT;
  localparam int FW = NX * NT;
  localparam int NK = NX * NY;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  frame_sel = 2'd0;
  logic        busy, done, rd_en;
  logic [16:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic        rd_data_a = 1'b0, rd_data_b = 1'b0, rd_data_c = 1'b0;
  logic [8:0]  kernel_out;
  logic        kernel_valid;
  logic        kernel_ready = 1'b1;
  logic [8:0]  kernel_x;
  logic [7:0]  kernel_y;
  logic        kernel_last;
  logic [2:0]  dbg_state;

  kernel_window_reader #(.X(NX), .THIRD_OF_Y(NT), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_sel(frame_sel),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
    .kernel_out(kernel_out), .kernel_valid(kernel_valid), .kernel_ready(kernel_ready),
    .kernel_x(kernel_x), .kernel_y(kernel_y), .kernel_last(kernel_last),
    .dbg_state(dbg_state)
  );

  // bank memories (one-cycle read) and frame images
  logic          mem [0:2][0:3*FW-1];
  logic [NK-1:0] img [0:2];

  function automatic logic mem_rd(input int b, input logic [16:0] a);
    if (a < 17'(3 * FW)) return mem[b][a];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_rd(0, rd_addr_a);
      rd_data_b <= mem_rd(1, rd_addr_b);
      rd_data_c <= mem_rd(2, rd_addr_c);
    end
  end

  // scoreboard state
  int tests = 0;
  int fails = 0;
  logic [26:0] exp_q[$];
  logic [50:0] addr_q[$];
  logic [8:0]  got_k [0:NK-1];
  logic [26:0] act_w;
  logic [26:0] stall_word;
  bit          stall_prev = 0;
  bit          done_due = 0;
  bit          first_pending = 0;
  logic [16:0] first_addr_a;
  int          hs_count = 0;
  int          rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // reference model: kernels and read addresses from the frame geometry
  task automatic push_expected(input int fs);
    int ef;
    logic [8:0] k;
    logic last;
    ef = (fs == 3) ? 0 : fs;
    for (int y = 0; y < NY; y++) begin
      for (int x = 0; x < NX; x++) begin
        k = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            k[(dr + 1) * 3 + (dc + 1)] =
              img[ef][clampi(y + dr, 0, NY - 1) * NX + clampi(x + dc, 0, NX - 1)];
          end
        end
        last = (x == NX - 1) && (y == NY - 1);
        exp_q.push_back({last, 8'(y), 9'(x), k});
      end
    end
  endtask

  task automatic push_addr_row(input int ef, input int y, input int col);
    logic [16:0] a [0:2];
    int rows [0:2];
    a[0] = '0; a[1] = '0; a[2] = '0;
    rows[0] = clampi(y - 1, 0, NY - 1);
    rows[1] = y;
    rows[2] = clampi(y + 1, 0, NY - 1);
    for (int i = 0; i < 3; i++) a[rows[i] % 3] = 17'(ef * FW + (rows[i] / 3) * NX + col);
    addr_q.push_back({a[2], a[1], a[0]});
  endtask

  task automatic push_addr(input int fs);
    int ef;
    ef = (fs == 3) ? 0 : fs;
    for (int y = 0; y < NY; y++) begin
      push_addr_row(ef, y, 0);
      for (int x = 0; x < NX; x++) push_addr_row(ef, y, clampi(x + 1, 0, NX - 1));
    end
  endtask

  // monitor: pops expectations whenever the DUT presents reads or kernels
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 0;
    end else begin
      act_w = {kernel_last, kernel_y, kernel_x, kernel_out};
      if (done_due) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        done_due = 0;
      end else if (done) begin
        flag("done_spurious");
      end
      if (rd_en) begin
        if (addr_q.size() == 0) flag("rd_addr_extra");
        else check("rd_addr", {rd_addr_c, rd_addr_b, rd_addr_a}, addr_q.pop_front());
        if (first_pending) begin
          first_addr_a = rd_addr_a;
          first_pending = 0;
        end
      end
      if (stall_prev) begin
        check("stall_valid", kernel_valid, 1);
        check("stall_hold", act_w, stall_word);
      end
      if (kernel_valid) begin
        check("rd_en_in_emit", rd_en, 0);
        if (kernel_ready) begin
          if (exp_q.size() == 0) flag("kernel_extra");
          else check("kernel", act_w, exp_q.pop_front());
          if (int'(kernel_y) * NX + int'(kernel_x) < NK)
            got_k[int'(kernel_y) * NX + int'(kernel_x)] = kernel_out;
          hs_count++;
          if (kernel_last) done_due = 1;
        end
      end
      stall_prev = kernel_valid && !kernel_ready;
      stall_word = act_w;
    end
  end

  // ready driver: 0 = always ready, 1 = random, 2 = driven by the test
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) kernel_ready = 1'b1;
      else if (rdy_mode == 1) kernel_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic load_frame(input int fs, input logic [NK-1:0] pix);
    img[fs] = pix;
    for (int r = 0; r < NY; r++)
      for (int c = 0; c < NX; c++)
        mem[r % 3][fs * FW + (r / 3) * NX + c] = pix[r * NX + c];
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_addr_a"}, rd_addr_a, 0);
    check({tag, "_addr_b"}, rd_addr_b, 0);
    check({tag, "_addr_c"}, rd_addr_c, 0);
    check({tag, "_kout"}, kernel_out, 0);
    check({tag, "_kvalid"}, kernel_valid, 0);
    check({tag, "_kx"}, kernel_x, 0);
    check({tag, "_ky"}, kernel_y, 0);
    check({tag, "_klast"}, kernel_last, 0);
  endtask

  task automatic pulse_start(input int fs);
    first_pending = 1;
    @(posedge clk); #1;
    start = 1'b1;
    frame_sel = 2'(fs);
    @(posedge clk); #1;
    start = 1'b0;
    frame_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic run_frame(input int fs, input bit extra_start, input bit stall);
    bit seen;
    bit released;
    seen = 0;
    released = 0;
    hs_count = 0;
    for (int i = 0; i < NK; i++) got_k[i] = 'x;
    push_expected(fs);
    push_addr(fs);
    pulse_start(fs);
    @(negedge clk);
    check("busy_in_pass", busy, 1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (extra_start && i == 10) begin start = 1'b1; frame_sel = 2'd2; end
      if (extra_start && i == 11) start = 1'b0;
      if (stall && !released && kernel_valid) begin
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          check("stall_kvalid", kernel_valid, 1);
          check("stall_rd_en", rd_en, 0);
          check("stall_kx", kernel_x, 0);
          check("stall_ky", kernel_y, 0);
        end
        @(posedge clk); #1;
        kernel_ready = 1'b1;
        rdy_mode = 0;
        released = 1;
      end
      if (done) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) flag("done_timeout");
    check("kernel_count", hs_count, NK);
    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    check("first_addr_a", first_addr_a, 17'(((fs == 3) ? 0 : fs) * FW));
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    bit hit;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 3 * FW; i++) mem[b][i] = 1'b0;
    for (int f = 0; f < 3; f++) img[f] = '0;

    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_zero("reset");

    // all ones
    load_frame(0, '1);
    run_frame(0, 0, 0);

    // single pixel (1,1)
    load_frame(0, NK'(1) << (1 * NX + 1));
    run_frame(0, 0, 0);
    check("px11_at_1_1", got_k[1 * NX + 1], 9'h010);
    check("px11_at_0_0", got_k[0], 9'h100);
    check("px11_at_2_2", got_k[2 * NX + 2], 9'h001);
    check("px11_at_3_0", got_k[3], 9'h000);

    // single pixel (0,0): left/top edge replication
    load_frame(0, NK'(1));
    run_frame(0, 0, 0);
    check("px00_at_0_0", got_k[0], 9'h01B);
    check("px00_at_1_0", got_k[1], 9'h009);

    // stall at the first kernel
    rdy_mode = 2;
    kernel_ready = 1'b0;
    run_frame(0, 0, 1);

    // other frame slots, slot 3 aliasing slot 0, start while busy
    load_frame(1, NK'($urandom()));
    load_frame(2, NK'($urandom()));
    run_frame(2, 0, 0);
    run_frame(3, 0, 0);
    run_frame(1, 1, 0);

    // reset in the middle of row 1
    push_expected(0);
    push_addr(0);
    pulse_start(0);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (kernel_valid && kernel_y == 8'd1 && kernel_x == 9'd1) begin
        hit = 1;
        break;
      end
    end
    if (!hit) flag("reach_row1_timeout");
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    done_due = 0;
    @(negedge clk);
    check_zero("midreset");
    repeat (5) @(negedge clk);
    run_frame(0, 0, 0);

    // random frames, slots and back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 6; n++) begin
      for (int f = 0; f < 3; f++) load_frame(f, NK'($urandom()));
      run_frame($urandom_range(0, 3), 0, 0);
    end
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
